muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the issue logic and the iterative multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [5:0]      RDin;
    logic            busy;
    logic            done;
    logic [5:0]      RD;
    logic [XLEN-1:0] WRD;
    logic            Wreg;

    modport master (
        output start, op, A, B, RDin,
        input  busy, done, RD, WRD, Wreg
    );

    modport slave (
        input  start, op, A, B, RDin,
        output busy, done, RD, WRD, Wreg
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: one bit per cycle, fixed 32-iteration latency,
// registered register-file write port.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [5:0]        cnt_r;
    logic [1:0]        op_r;
    logic [5:0]        rd_idx_r;
    logic [XLEN-1:0]   mcand_r;
    logic [XLEN-1:0]   dvsr_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN:0]     rem_r;
    logic [XLEN-1:0]   quo_r;

    logic              busy_r;
    logic              done_r;
    logic              wreg_r;
    logic [XLEN-1:0]   wrd_r;
    logic [5:0]        rd_r;

    logic [XLEN:0]     sum_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [XLEN:0]     shift_s;
    logic [XLEN+1:0]   diff_s;
    logic [XLEN:0]     rem_next_s;
    logic [XLEN-1:0]   quo_next_s;
    logic [XLEN-1:0]   result_s;
    logic              last_iter_s;

    assign last_iter_s = (cnt_r == 6'(XLEN - 1));

    // Next-state logic of the control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = bus.op[1] ? DIV : MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // One shift-add step and one restoring-division step, plus final result selection.
    always_comb begin
        sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        acc_next_s = {sum_s, acc_r[XLEN-1:1]};
        shift_s    = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
        diff_s     = {1'b0, shift_s} - {2'b00, dvsr_r};
        // A borrow means the shifted remainder was smaller than the divisor: restore it.
        if (diff_s[XLEN+1]) begin
            rem_next_s = shift_s;
            quo_next_s = {quo_r[XLEN-2:0], 1'b0};
        end else begin
            rem_next_s = diff_s[XLEN:0];
            quo_next_s = {quo_r[XLEN-2:0], 1'b1};
        end
        case (op_r)
            2'b00:   result_s = acc_next_s[XLEN-1:0];
            2'b01:   result_s = acc_next_s[2*XLEN-1:XLEN];
            2'b10:   result_s = quo_next_s;
            2'b11:   result_s = rem_next_s[XLEN-1:0];
            default: result_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= 6'd0;
            op_r     <= 2'b00;
            rd_idx_r <= 6'd0;
            mcand_r  <= {XLEN{1'b0}};
            dvsr_r   <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            rem_r    <= {(XLEN+1){1'b0}};
            quo_r    <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        cnt_r    <= 6'd0;
                        op_r     <= bus.op;
                        rd_idx_r <= bus.RDin;
                        mcand_r  <= bus.A;
                        dvsr_r   <= bus.B;
                        acc_r    <= {{XLEN{1'b0}}, bus.B};
                        rem_r    <= {(XLEN+1){1'b0}};
                        quo_r    <= bus.A;
                    end
                end
                MUL: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + 6'd1;
                end
                DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + 6'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered outputs; WRD/RD are loaded only when entering DONE and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            wreg_r <= 1'b0;
            wrd_r  <= {XLEN{1'b0}};
            rd_r   <= 6'd0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == DONE);
            wreg_r <= (state_next_s == DONE) && (rd_idx_r != 6'd0);
            if ((state_r == MUL || state_r == DIV) && last_iter_s) begin
                wrd_r <= result_s;
                rd_r  <= rd_idx_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Wreg = wreg_r;
    assign bus.WRD  = wrd_r;
    assign bus.RD   = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, busy-ignore, reset abort.
module tb_muldiv_unit;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Edge 0 = start edge. Inputs are scrambled after it; poke pulses start at edges 5, 32 and 33 (DONE).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] rd,
                          input logic [31:0] expv, input bit poke);
        int bad;
        bad = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.RDin  = rd;
        @(posedge clk);
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.Wreg !== 1'b0) bad++;
            bus.A     = $urandom;
            bus.B     = $urandom;
            bus.RDin  = 6'($urandom);
            bus.op    = 2'($urandom);
            bus.start = (poke && (e == 5 || e == 32)) ? 1'b1 : 1'b0;
            @(posedge clk);
        end
        check({tag, " busy-window errors"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " Wreg"}, {31'd0, bus.Wreg}, {31'd0, (rd != 6'd0)});
        check({tag, " RD"}, {26'd0, bus.RD}, {26'd0, rd});
        check({tag, " WRD"}, bus.WRD, expv);
        bus.start = poke;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " done after"}, {31'd0, bus.done}, 32'd0);
        check({tag, " busy after"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " WRD held"}, bus.WRD, expv);
    endtask

    initial begin
        int pulses;
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        bus.RDin  = 6'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset Wreg", {31'd0, bus.Wreg}, 32'd0);
        check("reset WRD", bus.WRD, 32'd0);
        check("reset RD", {26'd0, bus.RD}, 32'd0);

        run_op("mul 7x6",        2'b00, 32'd7,          32'd6,          6'd5,  32'd42,         1'b0);
        run_op("mul max",        2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  6'd1,  32'h0000_0001,  1'b0);
        run_op("mulhu max",      2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  6'd2,  32'hFFFF_FFFE,  1'b0);
        run_op("divu 100/7",     2'b10, 32'd100,        32'd7,          6'd3,  32'd14,         1'b0);
        run_op("remu 100/7",     2'b11, 32'd100,        32'd7,          6'd4,  32'd2,          1'b0);
        run_op("divu 5/0",       2'b10, 32'd5,          32'd0,          6'd6,  32'hFFFF_FFFF,  1'b0);
        run_op("remu 5/0",       2'b11, 32'd5,          32'd0,          6'd7,  32'd5,          1'b0);
        run_op("divu max/1",     2'b10, 32'hFFFF_FFFF,  32'd1,          6'd8,  32'hFFFF_FFFF,  1'b0);
        run_op("remu max/16",    2'b11, 32'hFFFF_FFFF,  32'd16,         6'd9,  32'd15,         1'b0);
        run_op("mulhu 2^31x4",   2'b01, 32'h8000_0000,  32'd4,          6'd10, 32'd2,          1'b0);
        run_op("mul poked",      2'b00, 32'd7,          32'd6,          6'd5,  32'd42,         1'b1);
        run_op("divu rd0",       2'b10, 32'd100,        32'd7,          6'd0,  32'd14,         1'b0);

        // Abort at edge 10 with a simultaneous start that must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        bus.RDin  = 6'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort WRD cleared", bus.WRD, 32'd0);
        check("abort RD cleared", {26'd0, bus.RD}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.Wreg !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        check("abort no pulses", 32'(pulses), 32'd0);

        run_op("mul after abort", 2'b00, 32'd1000, 32'd1000, 6'd63, 32'd1000000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
